// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multicycle RV32 control FSM: opcode constants,
// state encoding, datapath mux encodings, the opcode class vector and the
// per-state control word together with its state-to-control mapping.
package multicycle_ctrl_fsm_pkg;

  localparam logic [6:0] OP_R_TYPE = 7'b0110011;
  localparam logic [6:0] OP_I_TYPE = 7'b0010011;
  localparam logic [6:0] OP_LW     = 7'b0000011;
  localparam logic [6:0] OP_SW     = 7'b0100011;
  localparam logic [6:0] OP_BR     = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_HALT   = 7'b1111111;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_ALUWB,
    S_MEMADDR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_BRANCH,
    S_JAL,
    S_HALT
  } state_t;

  // ALU control classes
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;
  localparam logic [1:0] ALU_JAL   = 2'b11;

  // Register write-back source
  localparam logic [1:0] MTR_ALU  = 2'b00;
  localparam logic [1:0] MTR_MDR  = 2'b01;
  localparam logic [1:0] MTR_LINK = 2'b10;

  // ALU operand selects
  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_RS1   = 2'b01;
  localparam logic [1:0] SRCA_OLDPC = 2'b10;
  localparam logic [1:0] SRCB_RS2   = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;

  // One-hot opcode class; exactly one bit is set for any opcode.
  typedef struct packed {
    logic r;
    logic i;
    logic ld;
    logic st;
    logic br;
    logic jal;
    logic halt;
    logic bad;
  } op_class_t;

  // Control word that depends on state alone. The fetch-accept strobes
  // (ir_write, fetch pc_write) and the store-accept retire depend on
  // mem_ready and are formed in the top level.
  typedef struct packed {
    logic       pc_write;
    logic       pc_write_br;
    logic       mem_read;
    logic       mem_write;
    logic       i_or_d;
    logic       reg_write;
    logic [1:0] mem_to_reg;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic       retire;
  } ctrl_t;

  // imm_b selects the immediate operand in S_EXEC (I-type) instead of rs2.
  function automatic ctrl_t state_ctrl(input state_t s, input logic imm_b);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_a = SRCA_PC;
        c.alu_src_b = SRCB_FOUR;
        c.alu_op    = ALU_ADD;
      end
      S_DECODE: begin
        c.alu_src_a = SRCA_OLDPC;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_EXEC: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = imm_b ? SRCB_IMM : SRCB_RS2;
        c.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MTR_ALU;
        c.retire     = 1'b1;
      end
      S_MEMADDR: begin
        c.alu_src_a = SRCA_RS1;
        c.alu_src_b = SRCB_IMM;
        c.alu_op    = ALU_ADD;
      end
      S_MEMRD: begin
        c.mem_read = 1'b1;
        c.i_or_d   = 1'b1;
      end
      S_MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = MTR_MDR;
        c.retire     = 1'b1;
      end
      S_MEMWR: begin
        c.mem_write = 1'b1;
        c.i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        c.alu_src_a   = SRCA_RS1;
        c.alu_src_b   = SRCB_RS2;
        c.alu_op      = ALU_BR;
        c.pc_write_br = 1'b1;
        c.retire      = 1'b1;
      end
      S_JAL: begin
        c.pc_write   = 1'b1;
        c.reg_write  = 1'b1;
        c.mem_to_reg = MTR_LINK;
        c.alu_op     = ALU_JAL;
        c.retire     = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// Control bus between the multicycle controller and its datapath.
//   master : the controller (takes opcode/mem_ready, drives strobes/status)
//   slave  : the datapath/memory side
// Signals: opcode (IR[6:0]), mem_ready, pc_write, pc_write_br, ir_write,
// mem_read, mem_write, i_or_d, reg_write, mem_to_reg, alu_src_a, alu_src_b,
// alu_op, retire, retired_cnt, halted, illegal.
interface multicycle_ctrl_fsm_if #(
  parameter int CNT_W   = 32,
  parameter int ALUOP_W = 2
);
  logic [6:0]         opcode;
  logic               mem_ready;
  logic               pc_write;
  logic               pc_write_br;
  logic               ir_write;
  logic               mem_read;
  logic               mem_write;
  logic               i_or_d;
  logic               reg_write;
  logic [1:0]         mem_to_reg;
  logic [1:0]         alu_src_a;
  logic [1:0]         alu_src_b;
  logic [ALUOP_W-1:0] alu_op;
  logic               retire;
  logic [CNT_W-1:0]   retired_cnt;
  logic               halted;
  logic               illegal;

  modport master (
    input  opcode, mem_ready,
    output pc_write, pc_write_br, ir_write, mem_read, mem_write, i_or_d,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire,
           retired_cnt, halted, illegal
  );

  modport slave (
    output opcode, mem_ready,
    input  pc_write, pc_write_br, ir_write, mem_read, mem_write, i_or_d,
           reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, retire,
           retired_cnt, halted, illegal
  );
endinterface

// File: rtl/multicycle_ctrl_fsm_classifier.sv
// Combinational opcode classifier.
//   opcode : IR[6:0]
//   cls    : one-hot class {r, i, ld, st, br, jal, halt, bad}
module opcode_classifier
  import multicycle_ctrl_fsm_pkg::*;
(
  input  logic [6:0] opcode,
  output op_class_t  cls
);

  always_comb begin
    // NOTE: default every combinational output before the case so that no
    // path leaves it unassigned and infers a latch.
    cls = '0;
    case (opcode)
      OP_R_TYPE: cls.r    = 1'b1;
      OP_I_TYPE: cls.i    = 1'b1;
      OP_LW:     cls.ld   = 1'b1;
      OP_SW:     cls.st   = 1'b1;
      OP_BR:     cls.br   = 1'b1;
      OP_JAL:    cls.jal  = 1'b1;
      OP_HALT:   cls.halt = 1'b1;
      default:   cls.bad  = 1'b1;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Sequenced control FSM for the multicycle RV32 datapath.
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : controller side of the control bus (opcode/mem_ready in,
//           strobes, mux selects, retire, retired_cnt, halted, illegal out)
// Parameters: MEM_HANDSHAKE (1: memory states wait for mem_ready),
// CNT_W (retired counter width), ALUOP_W (alu_op width, >= 2).
module multicycle_ctrl_fsm #(
  parameter int MEM_HANDSHAKE = 1,
  parameter int CNT_W         = 32,
  parameter int ALUOP_W       = 2
) (
  input logic                 clk,
  input logic                 reset,
  multicycle_ctrl_fsm_if.master bus
);
  import multicycle_ctrl_fsm_pkg::*;

  state_t           state;
  state_t           next_state;
  ctrl_t            ctrl_q;
  logic [CNT_W-1:0] retired_cnt;
  logic             halted;
  logic             illegal;
  op_class_t        cls;
  logic             ready_eff;
  logic             fetch_accept;
  logic             retire_w;

  opcode_classifier u_classifier (
    .opcode (bus.opcode),
    .cls    (cls)
  );

  assign ready_eff    = (MEM_HANDSHAKE == 0) ? 1'b1 : bus.mem_ready;
  assign fetch_accept = (state == S_FETCH) && ready_eff;
  // Stores retire in the cycle memory accepts the write, not on a later state.
  assign retire_w     = ctrl_q.retire || ((state == S_MEMWR) && ready_eff);

  always_comb begin
    next_state = state;
    case (state)
      S_FETCH:   if (ready_eff) next_state = S_DECODE;
      S_DECODE: begin
        if (cls.r || cls.i)          next_state = S_EXEC;
        else if (cls.ld || cls.st)   next_state = S_MEMADDR;
        else if (cls.br)             next_state = S_BRANCH;
        else if (cls.jal)            next_state = S_JAL;
        else if (cls.halt || cls.bad) next_state = S_HALT;
      end
      S_EXEC:    next_state = S_ALUWB;
      S_MEMADDR: next_state = cls.ld ? S_MEMRD : S_MEMWR;
      S_MEMRD:   if (ready_eff) next_state = S_MEMWB;
      S_MEMWR:   if (ready_eff) next_state = S_FETCH;
      S_ALUWB, S_MEMWB, S_BRANCH, S_JAL: next_state = S_FETCH;
      S_HALT:    next_state = S_HALT;
      default:   next_state = S_FETCH;
    endcase
  end

  // The control word is registered from the state being entered, so each
  // state's outputs come straight from flops.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (reset) begin
      state       <= S_FETCH;
      ctrl_q      <= state_ctrl(S_FETCH, 1'b0);
      retired_cnt <= '0;
      halted      <= 1'b0;
      illegal     <= 1'b0;
    end else begin
      state  <= next_state;
      ctrl_q <= state_ctrl(next_state, cls.i);
      if (retire_w) retired_cnt <= retired_cnt + CNT_W'(1);
      if (next_state == S_HALT) halted <= 1'b1;
      if ((state == S_DECODE) && cls.bad) illegal <= 1'b1;
    end
  end

  // While reset is high every control output is held at 0, even before the
  // reset edge has returned the state to S_FETCH.
  assign bus.pc_write    = !reset && (ctrl_q.pc_write || fetch_accept);
  assign bus.ir_write    = !reset && fetch_accept;
  assign bus.pc_write_br = !reset && ctrl_q.pc_write_br;
  assign bus.mem_read    = !reset && ctrl_q.mem_read;
  assign bus.mem_write   = !reset && ctrl_q.mem_write;
  assign bus.i_or_d      = !reset && ctrl_q.i_or_d;
  assign bus.reg_write   = !reset && ctrl_q.reg_write;
  assign bus.retire      = !reset && retire_w;
  assign bus.mem_to_reg  = reset ? 2'b00 : ctrl_q.mem_to_reg;
  assign bus.alu_src_a   = reset ? 2'b00 : ctrl_q.alu_src_a;
  assign bus.alu_src_b   = reset ? 2'b00 : ctrl_q.alu_src_b;
  assign bus.alu_op      = reset ? '0 : ALUOP_W'(ctrl_q.alu_op);
  assign bus.retired_cnt = retired_cnt;
  assign bus.halted      = halted;
  assign bus.illegal     = illegal;

endmodule
